onewire_ds18b20_slave: RTL
==========================

# onewire_ds18b20_slave

Synthesizable 1-Wire responder emulating the DS18B20 subset our temperature master uses: reset/presence, Skip ROM, Convert T and Read Scratchpad. It is the far end of the master's bus. In `sim_top` it is wired to the master's `O_ONE_WIRE`/`I_ONE_WIRE` through a wired-AND bus model, replacing hand-timed stimulus. On hardware it can stand in for a real sensor on a spare pin.

## Interface
- `CLKS_PER_US`, default 12: clk cycles per microsecond; drives the internal µs tick.
- `CONV_US`, default 750000: conversion time in µs. Benches override with a small value.
- `clk`  in  1: system clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `I_ONE_WIRE`  in  1: resolved bus level (raw, asynchronous).
- `O_ONE_WIRE`  out  1: bus drive; 0 = pull low, 1 = release. Reset value 1.
- `I_TEMP`  in  16: signed temperature, 1/16 °C, DS18B20 format. Sampled at conversion end.
- `O_CONVERT_START`  out  1: one-cycle pulse when Convert T is accepted. Reset value 0.
- `O_BUSY`  out  1: high while a conversion runs. Reset value 0.
- `O_CMD`  out  8: last received command byte. Reset value 0x00.
- `O_CMD_VALID`  out  1: one-cycle pulse when `O_CMD` updates. Reset value 0.

## Operation
- **Input path:** `I_ONE_WIRE` passes through a 2-flop synchronizer, then falling- and rising-edge detect.
- **Timing base:** a µs tick prescaler feeds a 10-bit low-time counter that saturates at 1023. It clears on each falling edge.
- **Bus reset:** low time ≥ 480 µs, measured at the rising edge, is a bus reset. It is accepted in every state, including mid-byte and mid-scratchpad. Effects:
  - go to PRES_WAIT;
  - clear the bit/byte counters;
  - leave any running conversion unaffected.
- **States:**
  - IDLE: waits for a bus reset only; all slots are ignored.
  - PRES_WAIT: 30 µs after the reset's rising edge → PRESENCE.
  - PRESENCE: `O_ONE_WIRE`=0 for 120 µs, then release → ROM_CMD.
  - ROM_CMD: receive 8 bits. 0xCC → FUNC_CMD. Any other byte → IDLE.
  - FUNC_CMD: receive 8 bits.
    - 0x44 → pulse `O_CONVERT_START`, set `O_BUSY`, go to CONVERT.
    - 0xBE → load the scratchpad, go to READ_SP.
    - Other bytes → IDLE.
  - CONVERT: every read slot returns 0 while `O_BUSY`, and 1 after it clears.
  - READ_SP: 72 read slots return bytes 0–8 in order, LSB first. Every later slot returns 1.
- **Write slot:** falling edge starts the slot. The bit is the synchronized line level 30 µs later. Bits shift in LSB first.
- **Read slot:**
  - On the falling edge, if the bit to send is 0, drive 0 for 30 µs from that edge; if it is 1, stay released.
  - The bit index advances on every falling edge in READ_SP/CONVERT.
- **Conversion:**
  - A µs counter of width clog2(`CONV_US`+1) counts to `CONV_US`.
  - At the end, latch `I_TEMP` into scratchpad bytes 0–1 and clear `O_BUSY`.
  - Before the first conversion completes, scratchpad temperature is 0x0550 (+85 °C).
  - A Convert T received while `O_BUSY` restarts the count and pulses `O_CONVERT_START` again.
- **Scratchpad contents:** TEMP_LSB, TEMP_MSB, 0x4B, 0x46, 0x7F, 0xFF, 0x0C, 0x10, CRC.
  - CRC is Dallas CRC-8 (x^8+x^5+x^4+1, reflected, init 0x00) over bytes 0–7.
  - CRC is computed serially while the bytes are shifted out, then transmitted as byte 8.
- **O_CMD:** `O_CMD`/`O_CMD_VALID` update after every completed ROM or function byte.
- **Own-drive masking:** falling edges caused by our own drive (PRESENCE, read-0) are not counted as new slots. Edge detect is masked while `O_ONE_WIRE`=0 and for 2 cycles after release.

## Timing
- **Detection latency:** 2-cycle synchronizer plus 1 cycle for edge detect.
- **Tolerance:** all µs durations are ±1 µs of tick quantization. Presence starts 30–31 µs after the reset's rising edge.
- **Pulse outputs:** `O_CONVERT_START` and `O_CMD_VALID` assert in the cycle after the 8th bit is sampled.
- **Reset:** asserting `rst_n` low forces every output to its reset value immediately. After release, state is IDLE with the bus released.
- **Short lows:** lows < 1 µs (glitches) between slots are treated as slots; no filtering beyond the synchronizer.

## Structure
- `onewire_pkg`: state enum, command constants (0xCC, 0x44, 0xBE), timing constants (480, 30, 120) and scratchpad constant bytes. Shared with the master.
- Sub-module `onewire_crc8`: serial CRC-8 with clear, bit-in and enable; 8-bit output.

## Test plan
- **Reset/presence:** bus low 500 µs then released → `O_ONE_WIRE` goes low 30 µs later for 120 µs.
- **Skip ROM + Convert T:** write 0xCC then 0x44 (CONV_US=100) →
  - `O_CMD_VALID` pulses twice with 0xCC then 0x44;
  - `O_CONVERT_START` pulses once;
  - read slots return 0 until 100 µs have elapsed, then 1.
- **Read scratchpad:** with `I_TEMP`=0x0191 latched, reset then 0xCC, 0xBE, then 72 read slots → bytes 91 01 4B 46 7F FF 0C 10 followed by a correct CRC. Slot 73 returns 1.
- **Unknown ROM command:** 0x55 after presence → IDLE; subsequent read slots are never driven low.
- **Reset mid-read:** a bus reset after 20 scratchpad bits → presence is issued, and a new 0xCC/0xBE sequence restarts from byte 0.
- **Async reset:** `rst_n` pulsed low during PRESENCE → `O_ONE_WIRE`=1 in the same cycle; state is IDLE.

Source files
------------

// File: rtl/onewire_pkg.sv
// Shared 1-Wire definitions: slave states, DS18B20 command bytes, bus timing
// and the fixed scratchpad bytes, plus the Dallas CRC-8 single-bit step.
package onewire_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRES_WAIT,
        ST_PRESENCE,
        ST_ROM_CMD,
        ST_FUNC_CMD,
        ST_CONVERT,
        ST_READ_SP
    } ow_state_t;

    localparam logic [7:0] CMD_SKIP_ROM  = 8'hCC;
    localparam logic [7:0] CMD_CONVERT_T = 8'h44;
    localparam logic [7:0] CMD_READ_SP   = 8'hBE;

    localparam int T_RESET_US     = 480;
    localparam int T_PRES_WAIT_US = 30;
    localparam int T_PRESENCE_US  = 120;
    localparam int T_SLOT_US      = 30;

    localparam logic [15:0] TEMP_POWER_ON = 16'h0550;
    localparam logic [7:0]  SP_TH         = 8'h4B;
    localparam logic [7:0]  SP_TL         = 8'h46;
    localparam logic [7:0]  SP_CONFIG     = 8'h7F;
    localparam logic [7:0]  SP_RSVD0      = 8'hFF;
    localparam logic [7:0]  SP_RSVD1      = 8'h0C;
    localparam logic [7:0]  SP_RSVD2      = 8'h10;

    // Reflected x^8+x^5+x^4+1: shift right, fold 0x8C in when the outgoing bit differs
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
        logic fb;
        fb = crc[0] ^ din;
        return {1'b0, crc[7:1]} ^ (fb ? 8'h8C : 8'h00);
    endfunction

endpackage

// File: rtl/onewire_crc8.sv
// Serial Dallas CRC-8, one data bit per enabled cycle, LSB-first order.
module onewire_crc8
    import onewire_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    input  logic       bit_in,
    output logic [7:0] crc
);

    // Clear has priority so a new scratchpad read always starts from 0x00
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc <= 8'h00;
        end else if (clr) begin
            crc <= 8'h00;
        end else if (en) begin
            crc <= crc8_step(crc, bit_in);
        end
    end

endmodule

// File: rtl/onewire_ds18b20_slave.sv
// DS18B20-subset 1-Wire responder: reset/presence, Skip ROM, Convert T and
// Read Scratchpad, with a serial CRC over the transmitted scratchpad bytes.
module onewire_ds18b20_slave
    import onewire_pkg::*;
#(
    parameter int CLKS_PER_US = 12,
    parameter int CONV_US     = 750000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               I_ONE_WIRE,
    output logic               O_ONE_WIRE,
    input  logic signed [15:0] I_TEMP,
    output logic               O_CONVERT_START,
    output logic               O_BUSY,
    output logic [7:0]         O_CMD,
    output logic               O_CMD_VALID
);

    localparam int PRE_W  = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
    localparam int CONV_W = $clog2(CONV_US + 1);

    logic              sync_p0, sync_p1, line_p2;
    logic [PRE_W-1:0]  pre_cnt;
    logic              us_tick;
    logic [9:0]        low_us;
    logic [1:0]        mask_cnt;
    logic              edge_mask, fall, rise, bus_reset;

    ow_state_t         state;
    logic [7:0]        slot_us;
    logic              slot_pending;
    logic [2:0]        bit_cnt;
    logic [6:0]        shreg;
    logic [7:0]        next_byte;
    logic              sample_now;
    logic [6:0]        rd_idx;
    logic [CONV_W-1:0] conv_cnt;
    logic signed [15:0] temp_reg;
    logic signed [15:0] sp_temp;
    logic [7:0]        tx_byte;
    logic              tx_bit;
    logic              crc_clr, crc_en;
    logic [7:0]        crc_val;

    // Two-flop synchronizer plus one delayed copy for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
            line_p2 <= 1'b1;
        end else begin
            sync_p0 <= I_ONE_WIRE;
            sync_p1 <= sync_p0;
            line_p2 <= sync_p1;
        end
    end

    assign us_tick = (pre_cnt == PRE_W'(CLKS_PER_US - 1));

    // Free-running microsecond prescaler
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pre_cnt <= '0;
        else if (us_tick) pre_cnt <= '0;
        else pre_cnt <= pre_cnt + PRE_W'(1);
    end

    // Edges we cause ourselves stay invisible until our release has propagated
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mask_cnt <= 2'd0;
        else if (!O_ONE_WIRE) mask_cnt <= 2'd2;
        else if (mask_cnt != 2'd0) mask_cnt <= mask_cnt - 2'd1;
    end

    assign edge_mask = !O_ONE_WIRE || (mask_cnt != 2'd0);
    assign fall      = line_p2 && !sync_p1 && !edge_mask;
    assign rise      = !line_p2 && sync_p1 && !edge_mask;
    assign bus_reset = rise && (low_us >= 10'(T_RESET_US));

    // Low-time counter: held at zero while high, saturates at 1023 us
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) low_us <= 10'd0;
        else if (sync_p1 || fall) low_us <= 10'd0;
        else if (us_tick && low_us != 10'd1023) low_us <= low_us + 10'd1;
    end

    assign next_byte  = {sync_p1, shreg};
    assign sample_now = slot_pending && (slot_us >= 8'(T_SLOT_US));

    // Scratchpad byte selected by the read-slot index; past byte 8 the line idles high
    always_comb begin
        tx_byte = 8'hFF;
        case (rd_idx[6:3])
            4'd0:    tx_byte = sp_temp[7:0];
            4'd1:    tx_byte = sp_temp[15:8];
            4'd2:    tx_byte = SP_TH;
            4'd3:    tx_byte = SP_TL;
            4'd4:    tx_byte = SP_CONFIG;
            4'd5:    tx_byte = SP_RSVD0;
            4'd6:    tx_byte = SP_RSVD1;
            4'd7:    tx_byte = SP_RSVD2;
            4'd8:    tx_byte = crc_val;
            default: tx_byte = 8'hFF;
        endcase
    end

    assign tx_bit  = (state == ST_CONVERT) ? !O_BUSY : tx_byte[rd_idx[2:0]];
    assign crc_en  = fall && (state == ST_READ_SP) && (rd_idx < 7'd64);
    assign crc_clr = sample_now && (bit_cnt == 3'd7) && (state == ST_FUNC_CMD)
                     && (next_byte == CMD_READ_SP);

    onewire_crc8 u_crc (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (crc_clr),
        .en     (crc_en),
        .bit_in (tx_bit),
        .crc    (crc_val)
    );

    // Protocol FSM with slot timing, conversion timer and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            O_ONE_WIRE      <= 1'b1;
            O_CONVERT_START <= 1'b0;
            O_BUSY          <= 1'b0;
            O_CMD           <= 8'h00;
            O_CMD_VALID     <= 1'b0;
            slot_us         <= 8'd0;
            slot_pending    <= 1'b0;
            bit_cnt         <= 3'd0;
            shreg           <= 7'd0;
            rd_idx          <= 7'd0;
            conv_cnt        <= '0;
            temp_reg        <= TEMP_POWER_ON;
            sp_temp         <= TEMP_POWER_ON;
        end else begin
            O_CMD_VALID     <= 1'b0;
            O_CONVERT_START <= 1'b0;
            if (us_tick && slot_us != 8'hFF) slot_us <= slot_us + 8'd1;

            // Conversion runs independently of the bus protocol, bus resets included
            if (O_BUSY) begin
                if (conv_cnt == CONV_W'(CONV_US)) begin
                    O_BUSY   <= 1'b0;
                    temp_reg <= I_TEMP;
                end else if (us_tick) begin
                    conv_cnt <= conv_cnt + CONV_W'(1);
                end
            end

            if (bus_reset) begin
                state        <= ST_PRES_WAIT;
                O_ONE_WIRE   <= 1'b1;
                slot_us      <= 8'd0;
                slot_pending <= 1'b0;
                bit_cnt      <= 3'd0;
                rd_idx       <= 7'd0;
            end else begin
                case (state)
                    ST_IDLE: ;
                    ST_PRES_WAIT: begin
                        if (slot_us >= 8'(T_PRES_WAIT_US)) begin
                            state      <= ST_PRESENCE;
                            O_ONE_WIRE <= 1'b0;
                            slot_us    <= 8'd0;
                        end
                    end
                    ST_PRESENCE: begin
                        if (slot_us >= 8'(T_PRESENCE_US)) begin
                            state        <= ST_ROM_CMD;
                            O_ONE_WIRE   <= 1'b1;
                            bit_cnt      <= 3'd0;
                            slot_pending <= 1'b0;
                        end
                    end
                    ST_ROM_CMD, ST_FUNC_CMD: begin
                        if (fall) begin
                            slot_pending <= 1'b1;
                            slot_us      <= 8'd0;
                        end else if (sample_now) begin
                            shreg        <= next_byte[7:1];
                            bit_cnt      <= bit_cnt + 3'd1;
                            slot_pending <= 1'b0;
                            if (bit_cnt == 3'd7) begin
                                O_CMD       <= next_byte;
                                O_CMD_VALID <= 1'b1;
                                if (state == ST_ROM_CMD) begin
                                    state <= (next_byte == CMD_SKIP_ROM) ? ST_FUNC_CMD : ST_IDLE;
                                end else if (next_byte == CMD_CONVERT_T) begin
                                    O_CONVERT_START <= 1'b1;
                                    O_BUSY          <= 1'b1;
                                    conv_cnt        <= '0;
                                    state           <= ST_CONVERT;
                                end else if (next_byte == CMD_READ_SP) begin
                                    sp_temp <= temp_reg;
                                    rd_idx  <= 7'd0;
                                    state   <= ST_READ_SP;
                                end else begin
                                    state <= ST_IDLE;
                                end
                            end
                        end
                    end
                    ST_CONVERT, ST_READ_SP: begin
                        if (fall) begin
                            slot_us <= 8'd0;
                            if (!tx_bit) O_ONE_WIRE <= 1'b0;
                            if (rd_idx != 7'd72) rd_idx <= rd_idx + 7'd1;
                        end else if (!O_ONE_WIRE && slot_us >= 8'(T_SLOT_US)) begin
                            O_ONE_WIRE <= 1'b1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
